// File: rtl/alu_iter_if.sv
// Request/response bundle for the iterative ALU: operand handshake in,
// registered result plus flags out.
interface alu_iter_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             flag_c;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;

    modport master (
        output in_valid, a, b, alu_sel, out_ready,
        input  in_ready, out_valid, alu_out, flag_c, flag_z, flag_n, flag_v
    );

    modport slave (
        input  in_valid, a, b, alu_sel, out_ready,
        output in_ready, out_valid, alu_out, flag_c, flag_z, flag_n, flag_v
    );
endinterface

// File: rtl/alu_iter.sv
// Valid/ready ALU: logic, add/sub and shifts finish in one cycle; multiply is
// a shift-add loop taking WIDTH cycles. Result and flags are registered.
module alu_iter #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_iter_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [2*WIDTH-1:0] acc_next_s;

    logic [WIDTH-1:0]   alu_out_r;
    logic               out_valid_r;
    logic               flag_c_r;
    logic               flag_z_r;
    logic               flag_n_r;
    logic               flag_v_r;

    logic               in_ready_s;
    logic               accept_s;
    logic               is_mul_s;
    logic               last_iter_s;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH:0]     shl_s;
    logic [WIDTH:0]     shr_s;
    logic [WIDTH-1:0]   res_s;
    logic               c_s;
    logic               v_s;

    assign in_ready_s  = (state_r == IDLE) && (!out_valid_r || bus.out_ready);
    assign accept_s    = bus.in_valid && in_ready_s;
    assign is_mul_s    = (bus.alu_sel == 4'b1010);
    assign last_iter_s = (state_r == MUL) && (cnt_r == CW'(WIDTH - 1));

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.alu_out   = alu_out_r;
    assign bus.flag_c    = flag_c_r;
    assign bus.flag_z    = flag_z_r;
    assign bus.flag_n    = flag_n_r;
    assign bus.flag_v    = flag_v_r;

    // The extra bit in each shift holds the last bit pushed out (0 once b exceeds WIDTH).
    assign sum_s  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff_s = {1'b0, bus.a} - {1'b0, bus.b};
    assign shl_s  = {1'b0, bus.a} << bus.b;
    assign shr_s  = {bus.a, 1'b0} >> bus.b;

    assign acc_next_s = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});

    // Single-cycle result and carry/overflow selection.
    always_comb begin
        res_s = {WIDTH{1'b0}};
        c_s   = 1'b0;
        v_s   = 1'b0;
        case (bus.alu_sel)
            4'b0000: begin
                res_s = sum_s[WIDTH-1:0];
                c_s   = sum_s[WIDTH];
                v_s   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b0001: begin
                res_s = diff_s[WIDTH-1:0];
                c_s   = diff_s[WIDTH];
                v_s   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff_s[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b0010: res_s = bus.a & bus.b;
            4'b0011: res_s = bus.a | bus.b;
            4'b0100: res_s = bus.a ^ bus.b;
            4'b0101: res_s = ~(bus.a & bus.b);
            4'b0110: res_s = ~(bus.a | bus.b);
            4'b0111: res_s = ~(bus.a ^ bus.b);
            4'b1000: begin
                res_s = shl_s[WIDTH-1:0];
                c_s   = shl_s[WIDTH];
            end
            4'b1001: begin
                res_s = shr_s[WIDTH:1];
                c_s   = shr_s[0];
            end
            default: begin
                res_s = {WIDTH{1'b0}};
                c_s   = 1'b0;
                v_s   = 1'b0;
            end
        endcase
    end

    // FSM next-state: only an accepted multiply leaves IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && is_mul_s) begin
                    state_next_s = MUL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL: begin
                if (last_iter_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = MUL;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Shift-add multiplier: one partial product per cycle while in MUL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
        end else if (accept_s && is_mul_s) begin
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, bus.a};
            mplier_r <= bus.b;
        end else if (state_r == MUL) begin
            cnt_r    <= cnt_r + CW'(1);
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
        end else begin
            cnt_r    <= cnt_r;
            acc_r    <= acc_r;
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
        end
    end

    // Output register: load on single-cycle accept or final multiply step, hold under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            alu_out_r   <= {WIDTH{1'b0}};
            flag_c_r    <= 1'b0;
            flag_z_r    <= 1'b0;
            flag_n_r    <= 1'b0;
            flag_v_r    <= 1'b0;
        end else if (accept_s && !is_mul_s) begin
            out_valid_r <= 1'b1;
            alu_out_r   <= res_s;
            flag_c_r    <= c_s;
            flag_z_r    <= (res_s == {WIDTH{1'b0}});
            flag_n_r    <= res_s[WIDTH-1];
            flag_v_r    <= v_s;
        end else if (last_iter_s) begin
            out_valid_r <= 1'b1;
            alu_out_r   <= acc_next_s[WIDTH-1:0];
            flag_c_r    <= (acc_next_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
            flag_z_r    <= (acc_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
            flag_n_r    <= acc_next_s[WIDTH-1];
            flag_v_r    <= 1'b0;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
            alu_out_r   <= alu_out_r;
            flag_c_r    <= flag_c_r;
            flag_z_r    <= flag_z_r;
            flag_n_r    <= flag_n_r;
            flag_v_r    <= flag_v_r;
        end else begin
            out_valid_r <= out_valid_r;
            alu_out_r   <= alu_out_r;
            flag_c_r    <= flag_c_r;
            flag_z_r    <= flag_z_r;
            flag_n_r    <= flag_n_r;
            flag_v_r    <= flag_v_r;
        end
    end
endmodule

// File: tb/tb_alu_iter.sv
// Directed testbench for alu_iter at WIDTH=8; each task checks its own scenario inline.
module tb_alu_iter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [3:0] flags;

    alu_iter_if #(.WIDTH(8)) bus ();

    alu_iter #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign flags = {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [3:0] sel, input logic [7:0] aa, input logic [7:0] bb);
        bus.alu_sel  = sel;
        bus.a        = aa;
        bus.b        = bb;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = 8'h00; bus.b = 8'h00; bus.alu_sel = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.alu_out, flags} !== 13'h0000) begin
            errors++;
            $display("FAIL reset_state: got valid=%b out=%h flags=%b expected 0/00/0000", bus.out_valid, bus.alu_out, flags);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_add_sub();
        bus.out_ready = 1'b1;
        issue(4'b0000, 8'hFF, 8'h01);
        checks++;
        if ({bus.out_valid, bus.alu_out, flags} !== {1'b1, 8'h00, 4'b1100}) begin
            errors++;
            $display("FAIL add_ff_01: got valid=%b out=%h cznv=%b expected 1/00/1100", bus.out_valid, bus.alu_out, flags);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_drain: out_valid got %b expected 0", bus.out_valid);
        end
        issue(4'b0001, 8'h80, 8'h01);
        checks++;
        if ({bus.alu_out, flags} !== {8'h7F, 4'b0001}) begin
            errors++;
            $display("FAIL sub_80_01: got out=%h cznv=%b expected 7f/0001", bus.alu_out, flags);
        end
        @(posedge clk);
        #1;
        issue(4'b0001, 8'h01, 8'h02);
        checks++;
        if ({bus.alu_out, flags} !== {8'hFF, 4'b1010}) begin
            errors++;
            $display("FAIL sub_01_02: got out=%h cznv=%b expected ff/1010", bus.alu_out, flags);
        end
        @(posedge clk);
        #1;
        issue(4'b0000, 8'h7F, 8'h01);
        checks++;
        if ({bus.alu_out, flags} !== {8'h80, 4'b0011}) begin
            errors++;
            $display("FAIL add_7f_01: got out=%h cznv=%b expected 80/0011", bus.alu_out, flags);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_logic();
        logic [3:0] sel_tab [6] = '{4'b0010, 4'b0011, 4'b0101, 4'b0110, 4'b0111, 4'b1100};
        logic [7:0] exp_tab [6] = '{8'h05,   8'hAF,   8'hFA,   8'h50,   8'h55,   8'h00};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            issue(sel_tab[i], 8'hA5, 8'h0F);
            checks++;
            if ({bus.alu_out, flags} !== {exp_tab[i], 1'b0, exp_tab[i] == 8'h00, exp_tab[i][7], 1'b0}) begin
                errors++;
                $display("FAIL logic_sel_%b: got out=%h cznv=%b expected %h", sel_tab[i], bus.alu_out, flags, exp_tab[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_shift();
        bus.out_ready = 1'b1;
        issue(4'b1000, 8'h81, 8'd1);
        checks++;
        if ({bus.alu_out, flags} !== {8'h02, 4'b1000}) begin
            errors++;
            $display("FAIL shl_81_1: got out=%h cznv=%b expected 02/1000", bus.alu_out, flags);
        end
        issue(4'b1001, 8'h81, 8'd8);
        checks++;
        if ({bus.alu_out, flags} !== {8'h00, 4'b1100}) begin
            errors++;
            $display("FAIL shr_81_8: got out=%h cznv=%b expected 00/1100", bus.alu_out, flags);
        end
        issue(4'b1000, 8'h81, 8'd9);
        checks++;
        if ({bus.alu_out, flags} !== {8'h00, 4'b0100}) begin
            errors++;
            $display("FAIL shl_81_9: got out=%h cznv=%b expected 00/0100", bus.alu_out, flags);
        end
        issue(4'b1001, 8'h81, 8'd0);
        checks++;
        if ({bus.alu_out, flags} !== {8'h81, 4'b0010}) begin
            errors++;
            $display("FAIL shr_81_0: got out=%h cznv=%b expected 81/0010", bus.alu_out, flags);
        end
        issue(4'b1001, 8'h81, 8'd3);
        checks++;
        if ({bus.alu_out, flags} !== {8'h10, 4'b0000}) begin
            errors++;
            $display("FAIL shr_81_3: got out=%h cznv=%b expected 10/0000", bus.alu_out, flags);
        end
        issue(4'b1100, 8'hFF, 8'hFF);
        checks++;
        if ({bus.out_valid, bus.alu_out, flags} !== {1'b1, 8'h00, 4'b0100}) begin
            errors++;
            $display("FAIL op_1100: got valid=%b out=%h cznv=%b expected 1/00/0100", bus.out_valid, bus.alu_out, flags);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        int waited;
        bus.out_ready = 1'b1;
        issue(4'b1010, 8'h10, 8'h10);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
                errors++;
                $display("FAIL mul_busy_%0d: got ready=%b valid=%b expected 0/0", i, bus.in_ready, bus.out_valid);
            end
            if (i < 7) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.alu_out, flags} !== {1'b1, 8'h00, 4'b1100}) begin
            errors++;
            $display("FAIL mul_10_10: got valid=%b out=%h cznv=%b expected 1/00/1100", bus.out_valid, bus.alu_out, flags);
        end
        @(posedge clk);
        #1;
        issue(4'b1010, 8'h0F, 8'h0F);
        waited = 0;
        while (bus.out_valid !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checks++;
        if ({bus.out_valid, bus.alu_out, flags} !== {1'b1, 8'hE1, 4'b0010} || waited != 8) begin
            errors++;
            $display("FAIL mul_0f_0f: got valid=%b out=%h cznv=%b after %0d cycles expected 1/e1/0010 after 8", bus.out_valid, bus.alu_out, flags, waited);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        issue(4'b0100, 8'hA5, 8'h0F);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.alu_out} !== {1'b1, 1'b0, 8'hAA}) begin
                errors++;
                $display("FAIL hold_%0d: got valid=%b ready=%b out=%h expected 1/0/aa", i, bus.out_valid, bus.in_ready, bus.alu_out);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: got %b expected 1", bus.in_ready);
        end
        issue(4'b0011, 8'h01, 8'h02);
        checks++;
        if ({bus.out_valid, bus.alu_out} !== {1'b1, 8'h03}) begin
            errors++;
            $display("FAIL b2b_or: got valid=%b out=%h expected 1/03", bus.out_valid, bus.alu_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: out_valid got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_in_mul();
        int seen;
        bus.out_ready = 1'b1;
        issue(4'b0001, 8'h01, 8'h02);
        issue(4'b1010, 8'h10, 8'h10);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if ({bus.out_valid, bus.alu_out, flags, bus.in_ready} !== {1'b0, 8'h00, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL mul_abort: got valid=%b out=%h flags=%b ready=%b expected 0/00/0000/1", bus.out_valid, bus.alu_out, flags, bus.in_ready);
        end
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mul_abort_silent: out_valid seen %0d cycles expected 0", seen);
        end
        issue(4'b0000, 8'h02, 8'h03);
        checks++;
        if ({bus.out_valid, bus.alu_out, flags} !== {1'b1, 8'h05, 4'b0000}) begin
            errors++;
            $display("FAIL add_after_reset: got valid=%b out=%h cznv=%b expected 1/05/0000", bus.out_valid, bus.alu_out, flags);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add_sub();
        test_logic();
        test_shift();
        test_mul();
        test_back_to_back();
        test_reset_in_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have ports a, b  input  WIDTH each  operands (unsigned, or two's complement for overflow flag).
REQ-007 SHALL have port alu_sel  input  4  opcode.
REQ-008 SHALL have port out_valid  output  1  result registered and held.
REQ-009 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-010 SHALL have port alu_out  output  WIDTH  registered result.
REQ-011 SHALL have ports flag_c, flag_z, flag_n, flag_v  output  1 each  carry, zero, negative, signed overflow.

Function
REQ-012 SHALL decode alu_sel: 0000 a+b; 0001 a-b; 0010 a&b; 0011 a|b; 0100 a^b; 0101 ~(a&b); 0110 ~(a|b); 0111 ~(a^b); 1000 a<<b; 1001 a>>b (logical); 1010 a*b (unsigned, low WIDTH bits); 1011-1111 result 0.
REQ-013 SHALL accept a request on a rising edge where in_valid and in_ready are both 1; operands and opcode sampled only then.
REQ-014 SHALL drive in_ready = (state==IDLE) and (out_valid==0 or out_ready==1), combinationally.
REQ-015 SHALL implement FSM states IDLE and MUL; IDLE->MUL on acceptance of opcode 1010; MUL->IDLE after WIDTH iterations; all other opcodes stay in IDLE.
REQ-016 Non-multiply ops SHALL load alu_out/flags and set out_valid at the acceptance edge (result visible the cycle after acceptance).
REQ-017 Multiply SHALL be shift-add, one partial product per cycle, 2*WIDTH-bit accumulator; result and out_valid set on the WIDTH-th edge after acceptance.
REQ-018 While out_valid=1 and out_ready=0, alu_out, flags, and out_valid SHALL hold unchanged.
REQ-019 On out_ready=1 with out_valid=1, out_valid SHALL clear next edge unless a new single-cycle request is accepted on the same edge, in which case the new result replaces the old with out_valid staying 1.
REQ-020 flag_z SHALL be 1 iff alu_out==0; flag_n SHALL equal alu_out[WIDTH-1].
REQ-021 flag_c: add = carry-out; sub = borrow (a<b unsigned); shifts = last bit shifted out for 1<=b<=WIDTH, else 0; multiply = 1 iff upper WIDTH product bits nonzero; all others 0.
REQ-022 flag_v: add/sub = two's-complement signed overflow; all others 0.
REQ-023 Shifts with b=0 SHALL return a; with b>=WIDTH SHALL return 0.
REQ-024 Opcodes 1011-1111 SHALL complete in one cycle with alu_out=0, flag_z=1, other flags 0.

Reset
REQ-025 On rising edge with rst_n=0: state=IDLE, out_valid=0, alu_out=0, all flags 0, multiply accumulator/counter cleared; in_ready evaluates to 1 in the following cycle if rst_n=1.
REQ-026 Reset during MUL SHALL abort the operation; no result is ever presented for it.
REQ-027 Reset SHALL take priority over any simultaneous handshake.

Verification (WIDTH=8)
REQ-028 add a=0xFF b=0x01, out_ready=1 -> next cycle out_valid=1, alu_out=0x00, C=1 Z=1 N=0 V=0.
REQ-029 sub a=0x80 b=0x01 -> alu_out=0x7F, C=0 Z=0 N=0 V=1; sub a=0x01 b=0x02 -> 0xFF, C=1 N=1 V=0.
REQ-030 mul a=0x10 b=0x10 -> in_ready=0 for 8 cycles, out_valid rises exactly 8 edges after acceptance, alu_out=0x00, C=1 Z=1; mul 0x0F*0x0F -> 0xE1, C=0.
REQ-031 backpressure: xor 0xA5^0x0F with out_ready=0 for 3 cycles -> alu_out=0x AA held, in_ready=0; out_ready=1 with new or 0x01|0x02 pending -> back-to-back accept, alu_out=0x03, out_valid stays 1.
REQ-032 rst_n=0 on 4th MUL cycle -> next cycle out_valid=0, alu_out=0, flags 0, in_ready=1; following add 0x02+0x03 -> 0x05.
REQ-033 shift: shl a=0x81 b=1 -> 0x02 C=1; shr a=0x81 b=8 -> 0x00 C=1; shl b=9 -> 0x00 C=0; opcode 1100 -> 0x00 Z=1.
